adder_rr_arbiter: RTL and testbench

//  Shares one ripple_adder_16bit between NREQ calculator requesters (keypad entry, BCD correction, mul/div sequencers).

---
 rtl/adder_rr_arbiter_pkg.sv | 21 ++
 rtl/adder_rr_arbiter_if.sv | 28 ++
 rtl/adder_rr_arbiter_adder.sv | 24 ++
 rtl/adder_rr_arbiter_rr_pick.sv | 42 ++++
 rtl/adder_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 188 ++++++++++++++++++
 6 files changed

// File: rtl/adder_rr_arbiter_pkg.sv
// Shared calculator constants, FSM state encoding and small elaboration helpers.
// Used by the arbiter top, its interface and its sub-modules.
package calc_pkg;

    localparam int ADD_W      = 16;
    localparam int MAX_NREQ   = 8;
    localparam int MAX_SETTLE = 8;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Index width that stays at least one bit wide for tiny requester counts.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Requester-side bundle of the shared adder: request handshake, operands, response strobe and busy.
// The arbiter is the slave; the requester cluster (or bench) is the master.
interface adder_rr_arbiter_if #(
    parameter int NREQ = 4
);
    import calc_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ADD_W-1:0] req_a;
    logic [NREQ*ADD_W-1:0] req_b;
    logic [NREQ-1:0]       req_sub;
    logic [NREQ-1:0]       rsp_valid;
    logic [ADD_W-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_sub,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, busy
    );

endinterface

// File: rtl/adder_rr_arbiter_adder.sv
// Plain 16-bit ripple-carry adder; the carry chain is long, so callers hold inputs steady.
// Purely combinational, no handshake.
module ripple_adder_16bit
    import calc_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < ADD_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping mod NREQ.
// Zero latency; no backpressure of its own, any=0 when nothing is valid.
module rr_pick
    import calc_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDXW = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    localparam int WW = IDXW + 1;

    logic [2*NREQ-1:0] rot;
    logic [WW-1:0]     win;

    // Rotating a doubled vector puts requester ptr at bit 0, so a plain low-first scan is fair.
    always_comb begin
        rot = {valid, valid} >> ptr;
        win = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win = WW'(k) + {1'b0, ptr};
                any = 1'b1;
            end
        end
        if (win >= WW'(NREQ)) begin
            win = win - WW'(NREQ);
        end
        idx   = win[IDXW-1:0];
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = any && (win == WW'(i));
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin share of one ripple adder; accept at T, one-cycle rsp_valid at T+SETTLE_CYCLES+1.
// req_ready only in IDLE for the picked requester; losers hold valid until their turn.
module adder_rr_arbiter
    import calc_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_rr_arbiter_if.slave bus
);

    localparam int IDXW = idx_w(NREQ);

    generate
        if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
            $error("adder_rr_arbiter: NREQ must be in 2..8");
        end
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > MAX_SETTLE) begin : g_bad_settle
            $error("adder_rr_arbiter: SETTLE_CYCLES must be in 1..8");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ADD_W-1:0] op_a;
    logic [ADD_W-1:0] op_b;
    logic             op_cin;
    logic [IDXW-1:0]  grant_idx;
    logic [IDXW-1:0]  rr_ptr;
    logic [ADD_W-1:0] sum_q;
    logic             cout_q;

    logic [NREQ-1:0]  pick_grant;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_any;
    logic             accept;
    logic [ADD_W-1:0] sel_a;
    logic [ADD_W-1:0] sel_b;
    logic             sel_sub;
    logic [ADD_W-1:0] add_sum;
    logic             add_cout;

    logic [NREQ-1:0]  ready_c;
    logic [NREQ-1:0]  rsp_valid_c;
    logic             busy_c;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The adder only ever sees the op_* registers, so its inputs cannot move while settling.
    ripple_adder_16bit u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept = (state == ST_IDLE) && pick_any;

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDXW'(i)) begin
                sel_a   = bus.req_a[i*ADD_W +: ADD_W];
                sel_b   = bus.req_b[i*ADD_W +: ADD_W];
                sel_sub = bus.req_sub[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pick_any) state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == '0) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_a      <= sel_a;
                op_b      <= sel_b ^ {ADD_W{sel_sub}};
                op_cin    <= sel_sub;
                grant_idx <= pick_idx;
                cnt       <= CNT_W'(SETTLE_CYCLES - 1);
            end
            if (state == ST_SETTLE) begin
                if (cnt == '0) begin
                    sum_q  <= add_sum;
                    cout_q <= add_cout;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (state == ST_RESP) begin
                rr_ptr <= (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_comb begin
        ready_c     = '0;
        rsp_valid_c = '0;
        busy_c      = 1'b0;
        case (state)
            ST_IDLE:   ready_c = pick_grant;
            ST_SETTLE: busy_c = 1'b1;
            ST_RESP: begin
                busy_c                 = 1'b1;
                rsp_valid_c[grant_idx] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: one instance with SETTLE_CYCLES=1, one with SETTLE_CYCLES=4.
// Expected sums, grant order and strobe timing are written out by hand.
module tb_adder_rr_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    adder_rr_arbiter_if #(.NREQ(4)) if1 ();
    adder_rr_arbiter_if #(.NREQ(4)) if2 ();

    adder_rr_arbiter #(.NREQ(4), .SETTLE_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    adder_rr_arbiter #(.NREQ(4), .SETTLE_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on the SETTLE_CYCLES=1 instance; operands are scrambled after accept.
    task automatic txn(input int i, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] esum, input logic ecout, input string tag);
        if1.req_valid[i]          = 1'b1;
        if1.req_a[16*i +: 16]     = a;
        if1.req_b[16*i +: 16]     = b;
        if1.req_sub[i]            = s;
        #1;
        check({tag, "_ready_T"}, 32'(if1.req_ready), 32'(1) << i);
        step();
        if1.req_valid[i]          = 1'b0;
        if1.req_a[16*i +: 16]     = ~a;
        if1.req_b[16*i +: 16]     = ~b;
        if1.req_sub[i]            = ~s;
        check({tag, "_busy_T1"}, 32'(if1.busy), 32'd1);
        check({tag, "_ready_T1"}, 32'(if1.req_ready), 32'd0);
        step();
        check({tag, "_rsp_valid_T2"}, 32'(if1.rsp_valid), 32'(1) << i);
        check({tag, "_sum"}, 32'(if1.rsp_sum), 32'(esum));
        check({tag, "_cout"}, 32'(if1.rsp_cout), 32'(ecout));
        step();
        check({tag, "_rsp_valid_T3"}, 32'(if1.rsp_valid), 32'd0);
        check({tag, "_busy_T3"}, 32'(if1.busy), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        if1.req_valid = '0; if1.req_a = '0; if1.req_b = '0; if1.req_sub = '0;
        if2.req_valid = '0; if2.req_a = '0; if2.req_b = '0; if2.req_sub = '0;
        step();
        step();
        check("rst_ready", 32'(if1.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
        check("rst_sum", 32'(if1.rsp_sum), 32'd0);
        check("rst_cout", 32'(if1.rsp_cout), 32'd0);
        check("rst_busy", 32'(if1.busy), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_ready", 32'(if1.req_ready), 32'd0);

        txn(0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, "add");
        txn(1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, "sub_borrow");
        txn(2, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, "sub_noborrow");
        txn(3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "wrap");

        // SETTLE_CYCLES=4: strobe lands exactly at T+5, busy T+1..T+5.
        if2.req_valid[0] = 1'b1;
        if2.req_a[15:0]  = 16'h8001;
        if2.req_b[15:0]  = 16'h8000;
        #1;
        check("s4_ready_T", 32'(if2.req_ready), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin
                if2.req_valid[0] = 1'b0;
                if2.req_a[15:0]  = 16'h1111;
                if2.req_b[15:0]  = 16'h2222;
            end
            check($sformatf("s4_busy_T%0d", k), 32'(if2.busy), (k <= 5) ? 32'd1 : 32'd0);
            check($sformatf("s4_rsp_valid_T%0d", k), 32'(if2.rsp_valid), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                check("s4_sum", 32'(if2.rsp_sum), 32'h0001);
                check("s4_cout", 32'(if2.rsp_cout), 32'd1);
            end
        end

        // All four held valid from a fresh reset: grants 0,1,2,3,0 every three cycles.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if1.req_a[16*i +: 16] = 16'h1000 * 16'(i + 1);
            if1.req_b[16*i +: 16] = 16'(i + 1);
            if1.req_sub[i]        = 1'b0;
        end
        if1.req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            int g;
            g = n % 4;
            check($sformatf("rr_ready_n%0d", n), 32'(if1.req_ready), 32'(1) << g);
            step();
            if (n == 4) if1.req_valid = '0;
            check($sformatf("rr_settle_ready_n%0d", n), 32'(if1.req_ready), 32'd0);
            step();
            check($sformatf("rr_resp_ready_n%0d", n), 32'(if1.req_ready), 32'd0);
            check($sformatf("rr_rsp_valid_n%0d", n), 32'(if1.rsp_valid), 32'(1) << g);
            check($sformatf("rr_sum_n%0d", n), 32'(if1.rsp_sum), 32'h1001 * 32'(g + 1));
            step();
        end

        // After a grant to 2, requesters 1 and 3 collide: 3 first, then 1.
        txn(2, 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, "pre_collide");
        if1.req_a[16*1 +: 16] = 16'h0010; if1.req_b[16*1 +: 16] = 16'h0001; if1.req_sub[1] = 1'b0;
        if1.req_a[16*3 +: 16] = 16'h0030; if1.req_b[16*3 +: 16] = 16'h0003; if1.req_sub[3] = 1'b0;
        if1.req_valid = 4'b1010;
        #1;
        check("collide_first", 32'(if1.req_ready), 32'b1000);
        step();
        if1.req_valid[3] = 1'b0;
        step();
        check("collide_rsp3", 32'(if1.rsp_valid), 32'b1000);
        check("collide_sum3", 32'(if1.rsp_sum), 32'h0033);
        step();
        check("collide_second", 32'(if1.req_ready), 32'b0010);
        step();
        if1.req_valid[1] = 1'b0;
        step();
        check("collide_rsp1", 32'(if1.rsp_valid), 32'b0010);
        check("collide_sum1", 32'(if1.rsp_sum), 32'h0011);
        step();

        // Reset while settling: transaction lost, outputs cleared, pointer back to 0.
        if1.req_a[16*2 +: 16] = 16'h0050; if1.req_b[16*2 +: 16] = 16'h0001; if1.req_sub[2] = 1'b0;
        if1.req_valid = 4'b0100;
        #1;
        check("mid_rst_accept", 32'(if1.req_ready), 32'b0100);
        step();
        if1.req_valid = '0;
        check("mid_rst_busy_before", 32'(if1.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(if1.busy), 32'd0);
        check("mid_rst_sum", 32'(if1.rsp_sum), 32'd0);
        check("mid_rst_cout", 32'(if1.rsp_cout), 32'd0);
        step();
        check("mid_rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
        if1.req_a[15:0] = 16'h0002; if1.req_b[15:0] = 16'h0003; if1.req_sub[0] = 1'b0;
        if1.req_valid = 4'b0011;
        #1;
        check("post_rst_winner", 32'(if1.req_ready), 32'b0001);
        step();
        if1.req_valid = '0;
        step();
        check("post_rst_rsp", 32'(if1.rsp_valid), 32'b0001);
        check("post_rst_sum", 32'(if1.rsp_sum), 32'h0005);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
